// File: rtl/apb_fifo_slave.sv
// APB completer bridging register accesses to a TX stream FIFO (APB writes -> stream)
// and an RX stream FIFO (stream -> APB reads), with wait states and timeout on full/empty.
module apb_fifo_slave #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        penable,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_write;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          w_capture;

  logic          r_pready;
  logic          r_pslverr;
  logic [31:0]   r_prdata;
  logic          w_done_set;
  logic          w_err_nxt;
  logic [31:0]   w_rdata_nxt;

  logic          w_apb_push_tx;
  logic          w_apb_pop_rx;
  logic          w_flush_tx;
  logic          w_flush_rx;

  logic [31:0]   r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [CW-1:0] r_tx_cnt;
  logic [31:0]   r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wptr, r_rx_rptr;
  logic [CW-1:0] r_rx_cnt;

  logic          w_tx_full, w_tx_valid, w_tx_pop;
  logic          w_rx_empty, w_rx_ready, w_rx_push;
  logic          w_mapped, w_blocked;
  logic [1:0]    w_reg;
  logic [7:0]    w_tx_cnt8, w_rx_cnt8;
  logic [31:0]   w_status;

  assign w_tx_full  = (r_tx_cnt == CW'(DEPTH));
  assign w_tx_valid = (r_tx_cnt != '0);
  assign w_tx_pop   = w_tx_valid && tx_ready;
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_ready = (r_rx_cnt != CW'(DEPTH));
  assign w_rx_push  = rx_valid && w_rx_ready;

  assign w_tx_cnt8  = 8'(r_tx_cnt);
  assign w_rx_cnt8  = 8'(r_rx_cnt);
  assign w_status   = {14'd0, w_rx_empty, w_tx_full, w_rx_cnt8, w_tx_cnt8};

  assign w_mapped   = (r_addr[31:4] == '0) && (r_addr[1:0] == 2'b00);
  assign w_reg      = r_addr[3:2];
  // A full TX FIFO is not blocking when the stream drains an entry on the same edge.
  assign w_blocked  = w_mapped &&
                      (( r_write && (w_reg == 2'd0) && w_tx_full && !tx_ready) ||
                       (!r_write && (w_reg == 2'd1) && w_rx_empty));

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_capture     = 1'b0;
    w_done_set    = 1'b0;
    w_err_nxt     = 1'b0;
    w_rdata_nxt   = '0;
    w_apb_push_tx = 1'b0;
    w_apb_pop_rx  = 1'b0;
    w_flush_tx    = 1'b0;
    w_flush_rx    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (psel && !penable) begin
          w_state_nxt = S_WAIT;
          w_capture   = 1'b1;
          w_timer_nxt = '0;
        end
      end
      S_WAIT: begin
        if (!psel) begin
          w_state_nxt = S_IDLE;
        end else if (!w_mapped) begin
          w_state_nxt = S_DONE;
          w_done_set  = 1'b1;
          w_err_nxt   = 1'b1;
        end else if (w_blocked) begin
          if (r_timer == TW'(TIMEOUT)) begin
            w_state_nxt = S_DONE;
            w_done_set  = 1'b1;
            w_err_nxt   = 1'b1;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end else begin
          w_state_nxt = S_DONE;
          w_done_set  = 1'b1;
          unique case (w_reg)
            2'd0: w_apb_push_tx = r_write;
            2'd1: begin
              if (!r_write) begin
                w_apb_pop_rx = 1'b1;
                w_rdata_nxt  = r_rx_mem[r_rx_rptr];
              end
            end
            2'd2: begin
              if (!r_write) w_rdata_nxt = w_status;
            end
            default: begin
              if (r_write) begin
                w_flush_tx = r_wdata[0];
                w_flush_rx = r_wdata[1];
              end
            end
          endcase
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      if (w_capture) begin
        r_addr  <= paddr;
        r_wdata <= pwdata;
        r_write <= pwrite;
      end
      r_pready  <= w_done_set;
      r_pslverr <= w_err_nxt;
      if (w_done_set) r_prdata <= w_rdata_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else if (w_flush_tx) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_apb_push_tx) r_tx_wptr <= r_tx_wptr + AW'(1);
      if (w_tx_pop)      r_tx_rptr <= r_tx_rptr + AW'(1);
      if (w_apb_push_tx && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + CW'(1);
      else if (!w_apb_push_tx && w_tx_pop) r_tx_cnt <= r_tx_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_apb_push_tx) r_tx_mem[r_tx_wptr] <= r_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else if (w_flush_rx) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push)    r_rx_wptr <= r_rx_wptr + AW'(1);
      if (w_apb_pop_rx) r_rx_rptr <= r_rx_rptr + AW'(1);
      if (w_rx_push && !w_apb_pop_rx)      r_rx_cnt <= r_rx_cnt + CW'(1);
      else if (!w_rx_push && w_apb_pop_rx) r_rx_cnt <= r_rx_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push && !w_flush_rx) r_rx_mem[r_rx_wptr] <= rx_data;
  end

  assign prdata   = r_prdata;
  assign pready   = r_pready;
  assign pslverr  = r_pslverr;
  // Head is masked while empty so the stream data reads 0 out of reset.
  assign tx_data  = w_tx_valid ? r_tx_mem[r_tx_rptr] : '0;
  assign tx_valid = w_tx_valid;
  assign rx_ready = w_rx_ready;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Scoreboard bench for apb_fifo_slave: APB responses and TX stream words are queued
// at issue time and checked by independent monitors when the DUT presents them.
module tb_apb_fifo_slave;

  logic        clk;
  logic        rst;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  apb_fifo_slave #(.DEPTH(8), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pwrite   (pwrite),
    .psel     (psel),
    .penable  (penable),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk_rd;
    string       name;
  } exp_t;

  exp_t        apb_q[$];
  logic [31:0] tx_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b1 && pready === 1'b1) begin
      if (apb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pready actual=1 required=0");
      end else begin
        mon_e = apb_q.pop_front();
        chk({mon_e.name, "_pslverr"}, {31'd0, pslverr}, {31'd0, mon_e.err});
        if (mon_e.chk_rd) chk({mon_e.name, "_prdata"}, prdata, mon_e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx actual=0x%08h required=none", tx_data);
      end else begin
        chk("tx_data", tx_data, tx_q.pop_front());
      end
    end
  end

  // raise_at > 0 drives tx_ready high at the start of that access cycle.
  task automatic apb(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                     input logic [31:0] exp_rd, input logic exp_err, input bit chk_rd,
                     input int exp_waits, input int raise_at, input string name);
    exp_t e;
    int   n;
    e.rdata  = exp_rd;
    e.err    = exp_err;
    e.chk_rd = chk_rd;
    e.name   = name;
    apb_q.push_back(e);
    @(posedge clk); #1;
    paddr = addr; pwdata = wdata; pwrite = wr; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 1;
    if (raise_at == 1) tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (pready === 1'b1) break;
      if (n >= 64) begin
        checks++;
        failures++;
        $display("FAIL %s_pready_timeout actual=none required=pready", name);
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n == raise_at) tx_ready = 1'b1;
    end
    if (exp_waits >= 0) chk({name, "_waits"}, n - 1, exp_waits);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic drain_tx(input string name);
    int n;
    @(posedge clk); #1;
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk({name, "_remaining"}, tx_q.size(), 0);
    chk({name, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic rx_fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_data  = base + 32'(i);
      rx_valid = 1'b1;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready",   {31'd0, pready},   32'd0);
    chk("rst_pslverr",  {31'd0, pslverr},  32'd0);
    chk("rst_prdata",   prdata,            32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data",  tx_data,           32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Fill TX to depth, then drain in order.
    for (int i = 1; i <= 8; i++) begin
      apb(32'h0, 32'hA5A5_0000 + 32'(i), 1'b1, '0, 1'b0, 1'b0, 1, 0, "tx_wr");
      tx_q.push_back(32'hA5A5_0000 + 32'(i));
    end
    apb(32'h8, '0, 1'b0, 32'h0003_0008, 1'b0, 1'b1, 1, 0, "status_txfull");
    drain_tx("drain1");

    // Full TX: timeout, then unblock by a concurrent stream pop.
    for (int i = 0; i < 8; i++) begin
      apb(32'h0, 32'hB000_0000 + 32'(i), 1'b1, '0, 1'b0, 1'b0, 1, 0, "tx_wr2");
      tx_q.push_back(32'hB000_0000 + 32'(i));
    end
    apb(32'h0, 32'hDEAD_0000, 1'b1, '0, 1'b1, 1'b0, 17, 0, "tx_timeout");
    apb(32'h8, '0, 1'b0, 32'h0003_0008, 1'b0, 1'b1, 1, 0, "status_after_to");
    tx_q.push_back(32'hC0DE_0001);
    apb(32'h0, 32'hC0DE_0001, 1'b1, '0, 1'b0, 1'b0, 3, 3, "tx_unblock");
    drain_tx("drain2");
    apb(32'h8, '0, 1'b0, 32'h0002_0000, 1'b0, 1'b1, 1, 0, "status_empty");

    // RX single word, then empty-read timeout.
    rx_fill(32'h1234_5678, 1);
    apb(32'h4, '0, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 1, 0, "rx_pop");
    apb(32'h4, '0, 1'b0, '0, 1'b1, 1'b0, 17, 0, "rx_timeout");

    // RX full, then flush via CTRL.
    rx_fill(32'h5000_0000, 8);
    chk("rx_ready_full", {31'd0, rx_ready}, 32'd0);
    apb(32'h8, '0, 1'b0, 32'h0000_0800, 1'b0, 1'b1, 1, 0, "status_rxfull");
    apb(32'hC, 32'h2, 1'b1, '0, 1'b0, 1'b0, 1, 0, "flush_rx");
    chk("rx_ready_flushed", {31'd0, rx_ready}, 32'd1);
    apb(32'h8, '0, 1'b0, 32'h0002_0000, 1'b0, 1'b1, 1, 0, "status_flushed");

    // Unmapped and misaligned accesses.
    apb(32'h10, '0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 0, "unmapped_rd");
    apb(32'h2, 32'h1234, 1'b1, '0, 1'b1, 1'b0, 1, 0, "misaligned_wr");
    chk("misaligned_no_push", {31'd0, tx_valid}, 32'd0);

    // Mixed counts, pop order after flush, TX flush.
    rx_fill(32'h6000_0000, 3);
    apb(32'h0, 32'h7000_0000, 1'b1, '0, 1'b0, 1'b0, 1, 0, "tx_wr3");
    apb(32'h0, 32'h7000_0001, 1'b1, '0, 1'b0, 1'b0, 1, 0, "tx_wr3");
    tx_q.push_back(32'h7000_0000);
    tx_q.push_back(32'h7000_0001);
    apb(32'h8, '0, 1'b0, 32'h0000_0302, 1'b0, 1'b1, 1, 0, "status_mixed");
    apb(32'h4, '0, 1'b0, 32'h6000_0000, 1'b0, 1'b1, 1, 0, "rx_pop_order");
    apb(32'hC, 32'h1, 1'b1, '0, 1'b0, 1'b0, 1, 0, "flush_tx");
    tx_q.delete();
    apb(32'h8, '0, 1'b0, 32'h0000_0200, 1'b0, 1'b1, 1, 0, "status_txflushed");
    apb(32'h0, 32'h8000_0000, 1'b1, '0, 1'b0, 1'b0, 1, 0, "tx_wr4");
    chk("tx_head_pre_rst", tx_data, 32'h8000_0000);

    // Reset asserted while the access sits in WAIT.
    @(posedge clk); #1;
    paddr = 32'h4; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b0;
    #1;
    chk("midrst_pready",   {31'd0, pready},   32'd0);
    chk("midrst_prdata",   prdata,            32'd0);
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_tx_data",  tx_data,           32'd0);
    chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    apb(32'h8, '0, 1'b0, 32'h0002_0000, 1'b0, 1'b1, 1, 0, "status_after_rst");

    repeat (3) @(posedge clk);
    chk("apb_q_empty", apb_q.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
